fir_mac_sequencer: RTL

- Control FSM for a time-multiplexed, single-multiplier FIR datapath.
- Accepts one input sample over a valid/ready handshake and pulses the delay-line write.
- Steps a tap index through all taps, driving MAC clear/enable, then captures the result and presents it on an output valid/ready handshake.
- Sits between the top-level pin mapping and the FIR delay line, coefficient ROM and accumulator. Contains no datapath itself.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_tap_counter.sv | 45 ++++
 rtl/fir_mac_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared types and constants for the FIR MAC sequencer and datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fir_state_e;

  localparam int FIR_NUM_TAPS = 8;
  localparam int FIR_MAC_LAT  = 1;
  // Drain phase never exceeds four cycles, so two bits always suffice.
  localparam int DRAIN_W      = 2;

  function automatic int tap_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap_counter.sv
// ============================================================================
// Module   : fir_tap_counter
// Purpose  : Clearable up-counter with terminal-count flag at a given limit
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir_tap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Control FSM for a time-multiplexed single-multiplier FIR datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int MAC_LAT  = FIR_MAC_LAT,
  parameter int TAP_W    = tap_width(NUM_TAPS),
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_axis_fir_tvalid,
  output logic             s_axis_fir_tready,
  output logic             m_axis_fir_tvalid,
  input  logic             m_axis_fir_tready,
  output logic             smp_wr_en,
  output logic [TAP_W-1:0] tap_idx,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             out_load,
  output logic             busy,
  output logic [CNT_W-1:0] samples_done
);

  localparam logic [TAP_W-1:0]   TAP_LAST   = TAP_W'(NUM_TAPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_PRE  = (MAC_LAT > 1) ? DRAIN_W'(MAC_LAT - 2) : '0;
  localparam logic               LAT_ONE    = (MAC_LAT == 1);

  fir_state_e state_q, state_d;
  logic in_rdy_q, in_rdy_d;
  logic m_tvalid_q, m_tvalid_d;
  logic mac_en_q, mac_en_d;
  logic mac_clr_q, mac_clr_d;
  logic out_load_q, out_load_d;
  logic busy_q, busy_d;
  logic [CNT_W-1:0] samples_done_q, samples_done_d;

  logic               tap_tc;
  logic               drain_tc;
  logic [DRAIN_W-1:0] drain_cnt;

  // Tap counter doubles as the tap_idx register; it sits at 0 outside MAC.
  fir_tap_counter #(
    .W (TAP_W)
  ) u_tap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != MAC) || tap_tc),
    .en    (state_q == MAC),
    .last  (TAP_LAST),
    .cnt   (tap_idx),
    .tc    (tap_tc)
  );

  fir_tap_counter #(
    .W (DRAIN_W)
  ) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != DRAIN) || drain_tc),
    .en    (state_q == DRAIN),
    .last  (DRAIN_LAST),
    .cnt   (drain_cnt),
    .tc    (drain_tc)
  );

  always_comb begin
    state_d        = state_q;
    samples_done_d = samples_done_q;
    case (state_q)
      IDLE:  if (s_axis_fir_tvalid && in_rdy_q) state_d = MAC;
      MAC:   if (tap_tc) state_d = DRAIN;
      DRAIN: if (drain_tc) state_d = HOLD;
      HOLD: begin
        if (m_axis_fir_tready) begin
          state_d        = IDLE;
          samples_done_d = samples_done_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so each is derived from the state being entered.
    in_rdy_d   = (state_d == IDLE);
    mac_en_d   = (state_d == MAC);
    mac_clr_d  = (state_q == IDLE) && (state_d == MAC);
    out_load_d = ((state_q == MAC) && tap_tc && LAT_ONE) ||
                 ((state_q == DRAIN) && !LAT_ONE && (drain_cnt == DRAIN_PRE));
    m_tvalid_d = (state_d == HOLD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      in_rdy_q       <= 1'b0;
      m_tvalid_q     <= 1'b0;
      mac_en_q       <= 1'b0;
      mac_clr_q      <= 1'b0;
      out_load_q     <= 1'b0;
      busy_q         <= 1'b0;
      samples_done_q <= '0;
    end else begin
      state_q        <= state_d;
      in_rdy_q       <= in_rdy_d;
      m_tvalid_q     <= m_tvalid_d;
      mac_en_q       <= mac_en_d;
      mac_clr_q      <= mac_clr_d;
      out_load_q     <= out_load_d;
      busy_q         <= busy_d;
      samples_done_q <= samples_done_d;
    end
  end

  assign s_axis_fir_tready = in_rdy_q;
  assign smp_wr_en         = s_axis_fir_tvalid && in_rdy_q;
  assign m_axis_fir_tvalid = m_tvalid_q;
  assign mac_en            = mac_en_q;
  assign mac_clr           = mac_clr_q;
  assign out_load          = out_load_q;
  assign busy              = busy_q;
  assign samples_done      = samples_done_q;

endmodule

`default_nettype wire
